sr_chain_bist: RTL and testbench
================================

// Module: sr_chain_bist
// PURPOSE
//  Built-in self-test master for the latch shift-register chain. Drives the chain's serial input and samples
//  its serial output: flushes the chain, measures end-to-end latency with a single marker bit, then streams
//  PRBS7 and counts mismatches at the measured delay. Sits beside the chain on the same tile.
// PARAMETERS
//  SHIFT_DIV  2      clk cycles per bit period (one TX bit / one RX sample per strobe); >=1
//  MAX_LAT    255    max latency in strobes before timeout; also the FLUSH length; <= 2**LAT_W-1
//  LAT_W      8      width of latency result
//  NB_W       16     width of n_bits
//  ERR_W      16     width of err_cnt (saturating)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      reset, asynchronous, active-low
//  start      in   1      1-cycle request; sampled only in IDLE
//  n_bits     in   NB_W   PRBS bits to send; captured when start is accepted
//  sr_out     in   1      chain serial output
//  sr_in      out  1      chain serial input
//  busy       out  1      high from accepted start through the DONE cycle
//  done       out  1      1-cycle pulse at end of test
//  pass       out  1      result: !timeout && err_cnt==0; held until next accepted start
//  timeout    out  1      marker not seen, or chain stuck at 1; held
//  latency    out  LAT_W  measured chain delay in strobes; held
//  err_cnt    out  ERR_W  PRBS mismatches, saturates at all-ones; held
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, divider 0, PRBS regs 7'h7F.
//  - Strobe: divider counts 0..SHIFT_DIV-1, cleared on accepted start; strobe when divider==SHIFT_DIV-1.
//    On a strobe sr_out is sampled (pre-edge value) and sr_in updates. A bit driven at strobe k with chain
//    delay L is sampled at strobe k+L.
//  - States: IDLE -> FLUSH -> MARK -> PRBS -> DONE -> IDLE. Any state may jump to DONE on fault.
//  - IDLE: sr_in=0. start=1 -> capture n_bits, clear pass/timeout/latency/err_cnt, busy=1, go FLUSH.
//    start while busy is ignored.
//  - FLUSH: sr_in=0 for MAX_LAT strobes. If sr_out samples 1 on the last FLUSH strobe -> timeout=1, DONE.
//  - MARK: first strobe drives sr_in=1 (lat_cnt=0), later strobes sr_in=0, lat_cnt+1 per strobe.
//    Sample at marker strobe ignored (L>=1). First later strobe sampling 1 -> latency=lat_cnt, go PRBS.
//    lat_cnt reaches MAX_LAT with no 1 sampled -> timeout=1, latency=0, DONE.
//  - PRBS: TX PRBS7 x^7+x^6+1, seed 7'h7F, output bit = MSB, one step per strobe for n_bits strobes,
//    then sr_in=0. RX generator, identical and seeded identically, steps only on compare strobes. Compare
//    strobes s = latency .. n_bits+latency-1 (s counted from first PRBS strobe). Mismatch -> err_cnt+1,
//    saturating. After the last compare strobe -> DONE. n_bits==0 -> PRBS skipped, straight to DONE.
//  - DONE: one cycle; done=1, pass computed, busy drops next cycle. sr_in=0.
//  - Reset mid-operation: immediate return to reset values; no partial results retained.
// CONFIGURATION
//  SR_BIST_INJECT_EN defined: extra input port inject_err (1 bit). While inject_err=1 on a PRBS TX strobe,
//    the transmitted bit is inverted and the TX generator still advances normally. Each such strobe yields
//    exactly one mismatch.
//  Not defined: port absent; TX bit is always the PRBS bit.
// TESTING  (SHIFT_DIV=2, MAX_LAT=255; chain modelled as ideal D-strobe delay unless stated)
//  1 D=64, n_bits=100, start -> latency=64, err_cnt=0, timeout=0, pass=1, one done pulse, busy low after.
//  2 sr_out tied 0 -> timeout=1, latency=0, pass=0; done 255 strobes after MARK entry.
//  3 sr_out tied 1 -> timeout=1 at end of FLUSH, MARK never entered, pass=0.
//  4 D=64, model flips bit 10 of PRBS stream -> err_cnt=1, pass=0. Flip every bit with ERR_W=4 -> err_cnt=15.
//  5 rst_n low mid-PRBS -> all outputs 0 asynchronously; new start with D=3, n_bits=20 -> pass=1, latency=3.
//  6 SR_BIST_INJECT_EN, D=10, inject_err high for 3 PRBS strobes -> err_cnt=3. start while busy -> no effect.

Source files
------------

// File: rtl/sr_chain_bist.sv
// BIST master for the latch shift-register chain: flush, marker latency measurement, then a PRBS7 error count.
// Build option SR_BIST_INJECT_EN adds the inject_err port, which inverts transmitted PRBS bits.
module sr_chain_bist #(
  parameter int SHIFT_DIV = 2,
  parameter int MAX_LAT   = 255,
  parameter int LAT_W     = 8,
  parameter int NB_W      = 16,
  parameter int ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SR_BIST_INJECT_EN
  input  logic             inject_err,
`endif
  input  logic             start,
  input  logic [NB_W-1:0]  n_bits,
  input  logic             sr_out,
  output logic             sr_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [LAT_W-1:0] latency,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int         DIV_W     = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [6:0] PRBS_SEED = 7'h7F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_MARK,
    S_PRBS,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [LAT_W-1:0] r_cnt;
  logic             r_marked;
  logic [NB_W-1:0]  r_nbits;
  logic [NB_W-1:0]  r_tx_left;
  logic [NB_W-1:0]  r_rx_left;
  logic [6:0]       r_tx_lfsr;
  logic [6:0]       r_rx_lfsr;
  logic             r_sr_in;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_timeout;
  logic [LAT_W-1:0] r_latency;
  logic [ERR_W-1:0] r_err_cnt;

  logic             w_strobe;
  logic             w_start_ok;
  logic             w_inject;
  logic             w_tx_bit;
  logic             w_mismatch;
  logic [LAT_W-1:0] w_cnt_inc;

  // x^7 + x^6 + 1, output taken from the MSB, new bit enters at the LSB.
  function automatic logic [6:0] prbs_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  assign w_strobe   = (r_div == DIV_W'(SHIFT_DIV - 1));
  assign w_start_ok = (r_state == S_IDLE) && start;
`ifdef SR_BIST_INJECT_EN
  assign w_inject   = inject_err;
`else
  assign w_inject   = 1'b0;
`endif
  assign w_tx_bit   = r_tx_lfsr[6] ^ w_inject;
  assign w_mismatch = sr_out ^ r_rx_lfsr[6];
  assign w_cnt_inc  = r_cnt + LAT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values,
  // which is also what makes sr_out the value sampled just before the strobe edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_start_ok || w_strobe) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_marked  <= 1'b0;
      r_nbits   <= '0;
      r_tx_left <= '0;
      r_rx_left <= '0;
      r_tx_lfsr <= PRBS_SEED;
      r_rx_lfsr <= PRBS_SEED;
      r_sr_in   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_latency <= '0;
      r_err_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sr_in <= 1'b0;
          if (start) begin
            r_nbits   <= n_bits;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_latency <= '0;
            r_err_cnt <= '0;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_marked  <= 1'b0;
            r_tx_lfsr <= PRBS_SEED;
            r_rx_lfsr <= PRBS_SEED;
            r_state   <= S_FLUSH;
          end
        end

        // A 1 still coming out after a full flush means the chain is stuck high.
        S_FLUSH: begin
          if (w_strobe) begin
            r_sr_in <= 1'b0;
            if (r_cnt == LAT_W'(MAX_LAT - 1)) begin
              r_cnt <= '0;
              if (sr_out) begin
                r_timeout <= 1'b1;
                r_done    <= 1'b1;
                r_state   <= S_DONE;
              end else begin
                r_state <= S_MARK;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end

        S_MARK: begin
          if (w_strobe) begin
            if (!r_marked) begin
              r_sr_in  <= 1'b1;
              r_marked <= 1'b1;
            end else begin
              r_sr_in <= 1'b0;
              if (sr_out) begin
                r_latency <= w_cnt_inc;
                r_cnt     <= '0;
                r_tx_left <= r_nbits;
                r_rx_left <= r_nbits;
                if (r_nbits == '0) begin
                  r_pass  <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_state <= S_PRBS;
                end
              end else if (w_cnt_inc == LAT_W'(MAX_LAT)) begin
                r_timeout <= 1'b1;
                r_latency <= '0;
                r_done    <= 1'b1;
                r_state   <= S_DONE;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
          end
        end

        // TX streams n_bits bits; RX waits latency strobes, then checks n_bits samples.
        S_PRBS: begin
          if (w_strobe) begin
            if (r_tx_left != '0) begin
              r_sr_in   <= w_tx_bit;
              r_tx_lfsr <= prbs_step(r_tx_lfsr);
              r_tx_left <= r_tx_left - NB_W'(1);
            end else begin
              r_sr_in <= 1'b0;
            end

            if (r_cnt != r_latency) begin
              r_cnt <= w_cnt_inc;
            end else begin
              r_rx_lfsr <= prbs_step(r_rx_lfsr);
              r_rx_left <= r_rx_left - NB_W'(1);
              if (w_mismatch && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
              end
              if (r_rx_left == NB_W'(1)) begin
                r_pass  <= !w_mismatch && (r_err_cnt == '0);
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end
          end
        end

        S_DONE: begin
          r_sr_in <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sr_in   = r_sr_in;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign timeout = r_timeout;
  assign latency = r_latency;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_sr_chain_bist.sv
// Bench for sr_chain_bist: strobe-level chain model with optional bit flips, vector table, corner sequences, random runs.
`timescale 1ns/1ps
module tb_sr_chain_bist;

  localparam int SD    = 2;
  localparam int ML    = 255;
  localparam int LAT_W = 8;
  localparam int NB_W  = 16;
  localparam int ERR_W = 16;
  localparam int TXN   = 2048;

  typedef enum int {CH_IDEAL, CH_TIE0, CH_TIE1} chain_mode_e;

  typedef struct {
    chain_mode_e mode;
    int d;
    int n;
    int flip;
    int e_to;
    int e_lat;
    int e_err;
    int e_pass;
    int e_t;
    int e_hi;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [NB_W-1:0]  n_bits = '0;
  logic             sr_out = 1'b0;
`ifdef SR_BIST_INJECT_EN
  logic             inject_err = 1'b0;
`endif
  logic             sr_in, busy, done, pass, timeout;
  logic [LAT_W-1:0] latency;
  logic [ERR_W-1:0] err_cnt;
  logic             sr_in4, busy4, done4, pass4, timeout4;
  logic [LAT_W-1:0] latency4;
  logic [3:0]       err_cnt4;

  int          checks = 0;
  int          errors = 0;
  chain_mode_e ch_mode = CH_IDEAL;
  int          ch_d = 1;
  bit          flip_all = 1'b0;
  bit          flip_prbs [TXN];
  bit          tx [TXN];
  bit          prbs_ref [TXN];
  bit          hi_seen = 1'b0;
  bit          busy_q = 1'b0;
  int          scyc = 0;
  int          t_now = 0;

  always #5 clk = ~clk;

  sr_chain_bist #(.SHIFT_DIV(SD), .MAX_LAT(ML), .LAT_W(LAT_W), .NB_W(NB_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SR_BIST_INJECT_EN
    .inject_err(inject_err),
`endif
    .start(start), .n_bits(n_bits), .sr_out(sr_out), .sr_in(sr_in), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .latency(latency), .err_cnt(err_cnt)
  );

  sr_chain_bist #(.SHIFT_DIV(SD), .MAX_LAT(ML), .LAT_W(LAT_W), .NB_W(NB_W), .ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
`ifdef SR_BIST_INJECT_EN
    .inject_err(inject_err),
`endif
    .start(start), .n_bits(n_bits), .sr_out(sr_out), .sr_in(sr_in4), .busy(busy4), .done(done4),
    .pass(pass4), .timeout(timeout4), .latency(latency4), .err_cnt(err_cnt4)
  );

  // Chain model: strobe k is SD*k cycles after the accepting edge; the bit driven at strobe k
  // is presented to the sampler just before strobe k+ch_d, optionally inverted.
  always @(posedge clk) begin
    int k, j, pi;
    #1;
    if (busy && !busy_q) begin
      scyc    = 0;
      hi_seen = 1'b0;
      for (int i = 0; i < TXN; i++) tx[i] = 1'b0;
    end else if (busy) begin
      scyc++;
      if (scyc % SD == 0) begin
        k = scyc / SD;
        if (k < TXN) tx[k] = sr_in;
        if (sr_in) hi_seen = 1'b1;
      end
    end
    busy_q = busy;
    j  = scyc / SD + 1 - ch_d;
    pi = j - (ML + 2 + ch_d);
    case (ch_mode)
      CH_TIE0: sr_out = 1'b0;
      CH_TIE1: sr_out = 1'b1;
      default: begin
        if (!busy || j < 1 || j >= TXN) sr_out = 1'b0;
        else sr_out = tx[j] ^ ((pi >= 0) && (pi < TXN) && (flip_all || flip_prbs[pi]));
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      t_now++;
    end
  endtask

  task automatic clear_flips();
    flip_all = 1'b0;
    for (int i = 0; i < TXN; i++) flip_prbs[i] = 1'b0;
  endtask

  task automatic start_test(input chain_mode_e mode, input int d, input int n);
    ch_mode = mode;
    ch_d    = d;
    @(negedge clk);
    start  = 1'b1;
    n_bits = NB_W'(n);
    @(negedge clk);
    start  = 1'b0;
    n_bits = '1;
    t_now  = 0;
  endtask

  // Expected TX stream: zeros, marker at strobe ML+1, PRBS7 bits from strobe ML+2+d, then zeros.
  task automatic check_tx(input string tag, input int d, input int n);
    int last, bad, p0;
    bit want;
    p0   = ML + 2 + d;
    last = (n == 0) ? ML + 1 + d : ML + 1 + 2 * d + n;
    bad  = 0;
    for (int k = 1; k <= last; k++) begin
      if (k == ML + 1) want = 1'b1;
      else if (k >= p0 && k < p0 + n) want = prbs_ref[k - p0];
      else want = 1'b0;
      if (tx[k] != want) bad++;
    end
    check({tag, " tx_stream_bad_bits"}, bad, 0);
  endtask

  task automatic finish_test(input string tag, input int e_to, input int e_lat, input int e_err,
                             input int e_pass, input int e_t, input int e_hi, input bit do_tx,
                             input int d, input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    check({tag, " done_seen"}, ok, 1);
    if (ok) begin
      check({tag, " done_time"}, t_now, e_t);
      check({tag, " busy_at_done"}, busy, 1);
      check({tag, " timeout"}, timeout, e_to);
      check({tag, " latency"}, latency, e_lat);
      check({tag, " err_cnt"}, err_cnt, e_err);
      check({tag, " pass"}, pass, e_pass);
      check({tag, " sr_in_went_high"}, hi_seen, e_hi);
      check({tag, " e4_done"}, done4, 1);
      check({tag, " e4_err_sat"}, err_cnt4, (e_err > 15) ? 15 : e_err);
      check({tag, " e4_status"}, {busy4, pass4, timeout4, sr_in4, latency4}, {1'b1, e_pass[0], e_to[0], 1'b0, e_lat[7:0]});
      if (do_tx) check_tx(tag, d, n);
      tick(1);
      check({tag, " done_pulse_end"}, {done, busy}, 2'b00);
      check({tag, " results_held"}, {pass, timeout, latency}, {e_pass[0], e_to[0], e_lat[7:0]});
    end
  endtask

  vec_t vecs [7];
  int   d, n, nf, cnt, k0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 7; i++) prbs_ref[i] = 1'b1;
    for (int i = 7; i < TXN; i++) prbs_ref[i] = prbs_ref[i-7] ^ prbs_ref[i-6];
    clear_flips();

    vecs[0] = '{CH_IDEAL,  64, 100, -1, 0,  64, 0, 1,  968, 1};
    vecs[1] = '{CH_TIE0,   64, 100, -1, 1,   0, 0, 0, 1022, 1};
    vecs[2] = '{CH_TIE1,   64, 100, -1, 1,   0, 0, 0,  510, 0};
    vecs[3] = '{CH_IDEAL,  64, 100, 10, 0,  64, 1, 0,  968, 1};
    vecs[4] = '{CH_IDEAL,   5,   0, -1, 0,   5, 0, 1,  522, 1};
    vecs[5] = '{CH_IDEAL,   1,  16, -1, 0,   1, 0, 1,  548, 1};
    vecs[6] = '{CH_IDEAL, 255,   8, -1, 0, 255, 0, 1, 1548, 1};

    #23;
    check("reset outputs", {sr_in, busy, done, pass, timeout, latency, err_cnt}, 0);
    check("reset outputs e4", {sr_in4, busy4, done4, pass4, timeout4, latency4, err_cnt4}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);

    for (int v = 0; v < 7; v++) begin
      clear_flips();
      if (vecs[v].flip >= 0) flip_prbs[vecs[v].flip] = 1'b1;
      start_test(vecs[v].mode, vecs[v].d, vecs[v].n);
      finish_test($sformatf("vec%0d", v), vecs[v].e_to, vecs[v].e_lat, vecs[v].e_err, vecs[v].e_pass,
                  vecs[v].e_t, vecs[v].e_hi, vecs[v].mode == CH_IDEAL, vecs[v].d, vecs[v].n);
    end

    // Every PRBS bit inverted: the 4-bit counter saturates while the 16-bit one counts all 40.
    clear_flips();
    flip_all = 1'b1;
    start_test(CH_IDEAL, 20, 40);
    finish_test("flip_all", 0, 20, 40, 0, 2 * (ML + 1 + 40 + 40), 1, 1'b1, 20, 40);
    clear_flips();

    // A second start while busy must not restart or recapture n_bits.
    start_test(CH_IDEAL, 10, 30);
    tick(100);
    start  = 1'b1;
    n_bits = NB_W'(5);
    tick(1);
    start  = 1'b0;
    finish_test("start_while_busy", 0, 10, 0, 1, 2 * (ML + 1 + 20 + 30), 1, 1'b1, 10, 30);

    // Asynchronous reset in the middle of PRBS, then a fresh short run.
    start_test(CH_IDEAL, 64, 100);
    tick(2 * (ML + 1 + 64 + 30));
    check("mid_prbs latency", latency, 64);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {sr_in, busy, done, pass, timeout, latency, err_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    start_test(CH_IDEAL, 3, 20);
    finish_test("after_reset", 0, 3, 0, 1, 2 * (ML + 1 + 6 + 20), 1, 1'b1, 3, 20);

`ifdef SR_BIST_INJECT_EN
    // inject_err held across exactly three TX strobes (PRBS bits 5..7).
    start_test(CH_IDEAL, 10, 30);
    k0 = ML + 2 + 10 + 5;
    tick(SD * k0 - 1);
    inject_err = 1'b1;
    tick(2 * SD + 1);
    inject_err = 1'b0;
    finish_test("inject", 0, 10, 3, 0, 2 * (ML + 1 + 20 + 30), 1, 1'b0, 10, 30);
`endif

    // Random runs: expected errors are the flipped positions that fall inside the n_bits stream.
    for (int r = 0; r < 12; r++) begin
      d  = $urandom_range(1, 40);
      n  = (r == 3) ? 0 : $urandom_range(1, 60);
      nf = $urandom_range(0, 3);
      clear_flips();
      for (int f = 0; f < nf; f++) flip_prbs[$urandom_range(0, n + 4)] = 1'b1;
      cnt = 0;
      for (int i = 0; i < n; i++) if (flip_prbs[i]) cnt++;
      start_test(CH_IDEAL, d, n);
      finish_test($sformatf("rand%0d_d%0d_n%0d", r, d, n), 0, d, cnt, (cnt == 0) ? 1 : 0,
                  SD * ((n == 0) ? (ML + 1 + d) : (ML + 1 + 2 * d + n)), 1, 1'b1, d, n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
